// File: rtl/shift_rows_pkg.sv
// rtl/shift_rows_pkg.sv - byte type, row-offset and source-column helpers for ShiftRows/InvShiftRows
package shift_rows_pkg;

  typedef logic [7:0] byte_t;

  // Bit n set means NB = n columns is a legal Rijndael block width.
  localparam int NB_LEGAL_MASK = (1 << 4) | (1 << 6) | (1 << 8);

  function automatic bit nb_legal(input int nb);
    return (nb >= 0) && (nb < 31) && (((NB_LEGAL_MASK >> nb) & 1) == 1);
  endfunction

  // Rijndael row offsets: 0,1,2,3 for Nb = 4/6 and 0,1,3,4 for Nb = 8.
  function automatic int shift_offset(input int nb, input int aes_row);
    if ((nb == 8) && (aes_row >= 2)) begin
      return aes_row + 1;
    end
    return aes_row;
  endfunction

  // Column of the input state that feeds output column col for this row.
  function automatic int src_col(input int nb, input int col, input int aes_row, input bit decrypt);
    int s;
    s = shift_offset(nb, aes_row);
    if (decrypt) begin
      return (col + s) % nb;
    end
    return (col + nb - s) % nb;
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// rtl/shift_rows_perm.sv - combinational ShiftRows/InvShiftRows byte permutation for NB columns
module shift_rows_perm
  import shift_rows_pkg::*;
#(
  parameter int NB = 4
) (
  input  byte_t [NB-1:0][3:0] state_i,
  input  logic                decrypt_i,
  output byte_t [NB-1:0][3:0] state_o
);

  // Pure wiring: each output byte picks one of two fixed sources by direction.
  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar a = 0; a < 4; a++) begin : g_row
      localparam int ENC_SRC = src_col(NB, c, a, 1'b0);
      localparam int DEC_SRC = src_col(NB, c, a, 1'b1);
      assign state_o[c][3-a] = decrypt_i ? state_i[DEC_SRC][3-a] : state_i[ENC_SRC][3-a];
    end
  end

endmodule

// File: rtl/shift_rows_pipe.sv
// rtl/shift_rows_pipe.sv - registered ShiftRows/InvShiftRows stage with valid/ready and tag sideband
// Optional skid buffer (registered in_ready) enabled by defining SHIFT_ROWS_PIPE_SKID_EN.
module shift_rows_pipe
  import shift_rows_pkg::*;
#(
  parameter int NB    = 4,
  parameter int TAG_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_decrypt,
  input  logic [TAG_W-1:0]       in_tag,
  input  logic [NB-1:0][3:0][7:0] in_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_decrypt,
  output logic [TAG_W-1:0]       out_tag,
  output logic [NB-1:0][3:0][7:0] out_state
);

  if (!nb_legal(NB)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("shift_rows_pipe: TAG_W must be at least 1");
  end

  typedef byte_t [NB-1:0][3:0] state_t;

  state_t perm_state;

  shift_rows_perm #(
    .NB(NB)
  ) u_perm (
    .state_i  (in_state),
    .decrypt_i(in_decrypt),
    .state_o  (perm_state)
  );

  logic             out_valid_q, out_valid_d;
  logic             out_dec_q, out_dec_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  state_t           out_state_q, out_state_d;
  logic             in_fire;

`ifdef SHIFT_ROWS_PIPE_SKID_EN
  logic             skid_valid_q, skid_valid_d;
  logic             skid_dec_q, skid_dec_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  state_t           skid_state_q, skid_state_d;
  logic             in_ready_q;

  assign in_ready = in_ready_q;
  assign in_fire  = in_valid && in_ready_q;

  // in_ready only ever drops while the skid holds a beat, so an accepted
  // beat never meets a full skid; the skid always drains before new input.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_dec_d    = out_dec_q;
    out_tag_d    = out_tag_q;
    out_state_d  = out_state_q;
    skid_valid_d = skid_valid_q;
    skid_dec_d   = skid_dec_q;
    skid_tag_d   = skid_tag_q;
    skid_state_d = skid_state_q;
    if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_dec_d    = skid_dec_q;
        out_tag_d    = skid_tag_q;
        out_state_d  = skid_state_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_valid_d = 1'b1;
        out_dec_d   = in_decrypt;
        out_tag_d   = in_tag;
        out_state_d = perm_state;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_dec_d   = in_decrypt;
      skid_tag_d   = in_tag;
      skid_state_d = perm_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_valid_q <= 1'b0;
      skid_dec_q   <= 1'b0;
      skid_tag_q   <= '0;
      skid_state_q <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_dec_q   <= skid_dec_d;
      skid_tag_q   <= skid_tag_d;
      skid_state_q <= skid_state_d;
      in_ready_q   <= !skid_valid_d;
    end
  end
`else
  assign in_ready = !out_valid_q || out_ready;
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_dec_d   = out_dec_q;
    out_tag_d   = out_tag_q;
    out_state_d = out_state_q;
    if (in_fire) begin
      out_valid_d = 1'b1;
      out_dec_d   = in_decrypt;
      out_tag_d   = in_tag;
      out_state_d = perm_state;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_dec_q   <= 1'b0;
      out_tag_q   <= '0;
      out_state_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_dec_q   <= out_dec_d;
      out_tag_q   <= out_tag_d;
      out_state_q <= out_state_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_decrypt = out_dec_q;
  assign out_tag     = out_tag_q;
  assign out_state   = out_state_q;

endmodule
